// File: rtl/controlador_varredura_painel_pkg.sv
// Shared types and sizing helpers for the display panel scan sequencer.
package painel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } estado_t;

  localparam int SCAN_DIV_PADRAO   = 65536;
  localparam int SCROLL_DIV_PADRAO = 256;
  localparam int N_COLS_PADRAO     = 5;
  localparam int MSG_LEN_PADRAO    = 16;

  // Counter width for a modulus n; a modulus of 1 still needs one storage bit.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controlador_varredura_painel_if.sv
// Button-side commands in, panel demux / message ROM addressing out.
interface controlador_varredura_painel_if
  import painel_pkg::*;
#(
  parameter int N_COLS  = N_COLS_PADRAO,
  parameter int MSG_LEN = MSG_LEN_PADRAO
) ();

  logic                         start;
  logic                         stop;
  logic                         dir;
  logic                         home;
  logic                         busy;
  logic [largura(N_COLS)-1:0]   col_sel;
  logic [N_COLS-1:0]            col_en;
  logic [largura(MSG_LEN)-1:0]  scroll_pos;
  logic                         scan_tick;
  logic                         scroll_tick;
  logic                         frame_done;

  modport master (
    output start, stop, dir, home,
    input  busy, col_sel, col_en, scroll_pos, scan_tick, scroll_tick, frame_done
  );

  modport slave (
    input  start, stop, dir, home,
    output busy, col_sel, col_en, scroll_pos, scan_tick, scroll_tick, frame_done
  );

endinterface

// File: rtl/controlador_varredura_painel_divisor_tick.sv
// Enable-driven modulo-DIV counter; tick marks the enabled cycle that completes a count.
module divisor_tick
  import painel_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = largura(DIV);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == ULTIMO) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == ULTIMO);

endmodule

// File: rtl/controlador_varredura_painel.sv
// Panel scan sequencer: single-clock prescaled column scan and message scroll with run/stop control.
module controlador_varredura_painel
  import painel_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_PADRAO,
  parameter int SCROLL_DIV = SCROLL_DIV_PADRAO,
  parameter int N_COLS     = N_COLS_PADRAO,
  parameter int MSG_LEN    = MSG_LEN_PADRAO
) (
  input  logic                          clk,
  input  logic                          rst,
  controlador_varredura_painel_if.slave bus
);

  localparam int COL_W = largura(N_COLS);
  localparam int POS_W = largura(MSG_LEN);
  localparam logic [COL_W-1:0] COL_ULT = COL_W'(N_COLS - 1);
  localparam logic [POS_W-1:0] POS_ULT = POS_W'(MSG_LEN - 1);

  estado_t           estado;
  logic              busy;
  logic [COL_W-1:0]  col_sel;
  logic [COL_W-1:0]  col_prox;
  logic [N_COLS-1:0] col_en;
  logic [POS_W-1:0]  scroll_pos;
  logic              rodando;
  logic              partida;
  logic              scan_tick;
  logic              scroll_tick;
  logic              frame_done;

  function automatic logic [N_COLS-1:0] um_quente(input logic [COL_W-1:0] idx);
    return N_COLS'(1) << idx;
  endfunction

  // Explicit compare-and-wrap so non-power-of-2 message lengths stay in range.
  function automatic logic [POS_W-1:0] avanca_pos(input logic [POS_W-1:0] pos, input logic recua);
    if (recua) return (pos == '0) ? POS_ULT : pos - POS_W'(1);
    else       return (pos == POS_ULT) ? '0 : pos + POS_W'(1);
  endfunction

  assign rodando = (estado != IDLE);
  assign partida = (estado == IDLE) && bus.start;

  divisor_tick #(.DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (rodando),
    .clr  (partida),
    .tick (scan_tick)
  );

  divisor_tick #(.DIV(SCROLL_DIV)) u_div_scroll (
    .clk  (clk),
    .rst  (rst),
    .en   (scan_tick),
    .clr  (partida),
    .tick (scroll_tick)
  );

  assign frame_done = scan_tick && (col_sel == COL_ULT);
  assign col_prox   = scan_tick ? ((col_sel == COL_ULT) ? '0 : col_sel + COL_W'(1)) : col_sel;

  // col_en is written alongside col_sel so the demux never sees two columns lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= IDLE;
      busy    <= 1'b0;
      col_sel <= '0;
      col_en  <= '0;
    end else begin
      case (estado)
        IDLE: begin
          if (bus.start) begin
            estado  <= RUN;
            busy    <= 1'b1;
            col_sel <= '0;
            col_en  <= um_quente('0);
          end
        end
        RUN: begin
          if (bus.stop) estado <= DRAIN;
          col_sel <= col_prox;
          col_en  <= um_quente(col_prox);
        end
        DRAIN: begin
          if (frame_done) begin
            estado  <= IDLE;
            busy    <= 1'b0;
            col_sel <= '0;
            col_en  <= '0;
          end else begin
            col_sel <= col_prox;
            col_en  <= um_quente(col_prox);
          end
        end
        default: begin
          estado  <= IDLE;
          busy    <= 1'b0;
          col_sel <= '0;
          col_en  <= '0;
        end
      endcase
    end
  end

  // Offset survives stop and idle; home takes priority over a coincident scroll step.
  always_ff @(posedge clk) begin
    if (rst || bus.home) begin
      scroll_pos <= '0;
    end else if (scroll_tick) begin
      scroll_pos <= avanca_pos(scroll_pos, bus.dir);
    end
  end

  assign bus.busy        = busy;
  assign bus.col_sel     = col_sel;
  assign bus.col_en      = col_en;
  assign bus.scroll_pos  = scroll_pos;
  assign bus.scan_tick   = scan_tick;
  assign bus.scroll_tick = scroll_tick;
  assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_controlador_varredura_painel.sv
// Scoreboard bench for the panel scan sequencer against a cycles-since-start reference model.
module tb_controlador_varredura_painel;

  localparam int SD = 4;
  localparam int SR = 3;
  localparam int NC = 5;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controlador_varredura_painel_if #(.N_COLS(NC), .MSG_LEN(ML)) bus ();

  controlador_varredura_painel #(
    .SCAN_DIV(SD), .SCROLL_DIV(SR), .N_COLS(NC), .MSG_LEN(ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       busy;
    logic [2:0] col_sel;
    logic [4:0] col_en;
    logic [2:0] pos;
    logic       scan;
    logic       scroll;
    logic       frame;
  } saida_t;

  typedef struct {
    int     cyc;
    saida_t s;
  } item_t;

  item_t fila[$];
  int ciclo    = 0;
  int vetores  = 0;
  int erros    = 0;

  // Reference state: m_k = cycles since the run began (0 when idle).
  int m_k     = 0;
  bit m_drain = 1'b0;
  int m_pos   = 0;

  always @(posedge clk) ciclo++;

  function automatic saida_t m_saida();
    saida_t s;
    int n;
    int col;
    s = '0;
    if (m_k > 0) begin
      col       = ((m_k - 1) / SD) % NC;
      s.busy    = 1'b1;
      s.col_sel = 3'(col);
      s.col_en  = 5'(1 << col);
      if (m_k % SD == 0) begin
        n        = m_k / SD;
        s.scan   = 1'b1;
        s.frame  = (n % NC == 0);
        s.scroll = (n % SR == 0);
      end
    end
    s.pos = 3'(m_pos);
    return s;
  endfunction

  task automatic passo(input bit r, input bit st, input bit sp, input bit d, input bit h);
    saida_t cur;
    item_t  it;
    rst      = r;
    bus.start = st;
    bus.stop  = sp;
    bus.dir   = d;
    bus.home  = h;
    cur = m_saida();
    if (r) begin
      m_k = 0; m_drain = 1'b0; m_pos = 0;
    end else begin
      if (h)               m_pos = 0;
      else if (cur.scroll) m_pos = d ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
      if (m_k == 0) begin
        if (st) begin m_k = 1; m_drain = 1'b0; end
      end else if (m_drain && cur.frame) begin
        m_k = 0; m_drain = 1'b0;
      end else begin
        if (sp) m_drain = 1'b1;
        m_k++;
      end
    end
    it.cyc = ciclo + 1;
    it.s   = m_saida();
    fila.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    item_t  it;
    saida_t a;
    forever begin
      @(posedge clk);
      #2;
      while (fila.size() > 0 && fila[0].cyc <= ciclo) begin
        it        = fila.pop_front();
        a.busy    = bus.busy;
        a.col_sel = bus.col_sel;
        a.col_en  = bus.col_en;
        a.pos     = bus.scroll_pos;
        a.scan    = bus.scan_tick;
        a.scroll  = bus.scroll_tick;
        a.frame   = bus.frame_done;
        vetores++;
        if (a !== it.s || it.cyc != ciclo) begin
          erros++;
          $display("FAIL saidas ciclo %0d: got busy=%b col=%0d en=%b pos=%0d scan=%b scroll=%b frame=%b, exp busy=%b col=%0d en=%b pos=%0d scan=%b scroll=%b frame=%b",
                   ciclo, a.busy, a.col_sel, a.col_en, a.pos, a.scan, a.scroll, a.frame,
                   it.s.busy, it.s.col_sel, it.s.col_en, it.s.pos, it.s.scan, it.s.scroll, it.s.frame);
        end
      end
    end
  end

  initial begin : estimulo
    int lim;
    rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0; bus.home = 1'b0;
    @(posedge clk);
    #1;
    // Reset and quiet idle period.
    repeat (2) passo(1, 0, 0, 0, 0);
    repeat (50) passo(0, 0, 0, 0, 0);
    // Start, free run upward, then home and run downward.
    passo(0, 1, 0, 0, 0);
    repeat (60) passo(0, 0, 0, 0, 0);
    passo(0, 0, 0, 0, 1);
    repeat (30) passo(0, 0, 0, 1, 0);
    // Stop with column 2 lit, then drain to idle.
    lim = 0;
    while (m_saida().col_sel != 3'd2 && lim < 40) begin passo(0, 0, 0, 1, 0); lim++; end
    passo(0, 0, 1, 1, 0);
    lim = 0;
    while (m_k > 0 && lim < 60) begin passo(0, 0, 0, 0, 0); lim++; end
    repeat (5) passo(0, 0, 0, 0, 0);
    // start+stop in idle goes to run; home lands on a scroll tick.
    passo(0, 1, 1, 0, 0);
    lim = 0;
    while (!m_saida().scroll && lim < 100) begin passo(0, 0, 0, 0, 0); lim++; end
    passo(0, 0, 0, 0, 1);
    repeat (7) passo(0, 0, 0, 0, 0);
    // start+stop in run drains; reset lands mid-drain at column 3.
    passo(0, 1, 1, 0, 0);
    lim = 0;
    while (m_saida().col_sel != 3'd3 && lim < 40) begin passo(0, 0, 0, 0, 0); lim++; end
    passo(1, 0, 0, 0, 0);
    repeat (5) passo(0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      passo($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 39) == 0);
    end
    repeat (3) passo(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    if (fila.size() != 0) begin
      erros++;
      $display("FAIL fila_pendente: got %0d entries left, exp 0", fila.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
